// File: rtl/vote_logger.sv
// vote_logger: four-candidate vote tally with single-press acceptance.
//
// A vote is accepted when exactly one candidate input is high while the
// logger is idle and in voting mode. Simultaneous presses are rejected.
// After an accept or a reject, the logger locks until every candidate
// input has been released.
//
// Optional feature (macro VOTE_SATURATE_EN):
//   defined   - a full tally holds at its maximum value on an accepted vote
//   undefined - a full tally wraps to zero on an accepted vote
//
// Ports:
//   clk                       system clock, rising edge
//   rst                       synchronous active-high reset
//   mode                      0 = voting, 1 = result display
//   cand1_vote..cand4_vote    qualified vote levels from the button stages
//   cand1_count..cand4_count  tallies (shown only when mode = 1, else zero)
//   vote_ack                  one-cycle pulse after an accepted vote
//   vote_reject               one-cycle pulse after a rejected multi-press
//   busy                      high while the logger is locked
module vote_logger #(
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic               cand1_vote,
   input  logic               cand2_vote,
   input  logic               cand3_vote,
   input  logic               cand4_vote,
   output logic [COUNT_W-1:0] cand1_count,
   output logic [COUNT_W-1:0] cand2_count,
   output logic [COUNT_W-1:0] cand3_count,
   output logic [COUNT_W-1:0] cand4_count,
   output logic               vote_ack,
   output logic               vote_reject,
   output logic               busy
);

   localparam int unsigned NUM_CAND = 4;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t                    state;
   state_t                    state_nxt;
   logic [NUM_CAND-1:0]       votes;
   logic                      any_vote;
   logic                      multi_vote;
   logic                      accept;
   logic                      reject;
   logic [COUNT_W-1:0]        tally [NUM_CAND];

   assign votes    = {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
   assign any_vote = |votes;
   // Clearing the lowest set bit leaves a nonzero value only for two or more presses.
   assign multi_vote = |(votes & (votes - NUM_CAND'(1)));

   // Next tally value on an accepted vote.
   function automatic logic [COUNT_W-1:0] bump(input logic [COUNT_W-1:0] v);
`ifdef VOTE_SATURATE_EN
      return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
`else
      return v + COUNT_W'(1);
`endif
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and accept/reject decode.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            if (!mode && any_vote) begin
               state_nxt = LOCK;
               if (multi_vote) reject = 1'b1;
               else            accept = 1'b1;
            end
         end
         LOCK: begin
            // The lock releases on full release only, whatever the mode.
            if (!any_vote) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Tallies and registered status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
         vote_ack    <= 1'b0;
         vote_reject <= 1'b0;
         busy        <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (accept && votes[i]) tally[i] <= bump(tally[i]);
         end
         vote_ack    <= accept;
         vote_reject <= reject;
         busy        <= (state_nxt == LOCK);
      end
   end

   // Display gating follows mode without a clock delay.
   assign cand1_count = mode ? tally[0] : '0;
   assign cand2_count = mode ? tally[1] : '0;
   assign cand3_count = mode ? tally[2] : '0;
   assign cand4_count = mode ? tally[3] : '0;

endmodule
